// File: rtl/fc_result_streamer.sv
// Captures one vector of accumulated sums, rescales/saturates each to DATA_WIDTH,
// and streams the words one per beat over a valid/ready interface.
module fc_result_streamer #(
   parameter int DATA_WIDTH  = 16,
   parameter int ACC_WIDTH   = 32,
   parameter int NUM_NEURONS = 10,
   parameter int FRAC_SHIFT  = 8,
   parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               acc_valid,
   output logic                               acc_ready,
   input  logic [NUM_NEURONS*ACC_WIDTH-1:0]   acc_data,
   output logic                               m_valid,
   input  logic                               m_ready,
   output logic [DATA_WIDTH-1:0]              m_data,
   output logic [IDX_W-1:0]                   m_index,
   output logic                               m_last,
   output logic                               busy,
   output logic [7:0]                         sat_count
);

   typedef enum logic {IDLE, SEND} state_t;

   localparam logic signed [ACC_WIDTH-1:0] MAX_S = ACC_WIDTH'(2**(DATA_WIDTH-1) - 1);
   localparam logic signed [ACC_WIDTH-1:0] MIN_S = -MAX_S - 1;
   localparam logic [DATA_WIDTH-1:0]       MAX_W = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0]       MIN_W = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   state_t                 r_state, w_nextState;
   logic [ACC_WIDTH-1:0]   r_acc [NUM_NEURONS];
   logic [IDX_W-1:0]       r_idx;
   logic [DATA_WIDTH-1:0]  r_data;
   logic                   r_last;
   logic                   r_sat;
   logic [7:0]             r_satCount;

   logic                   w_capture, w_advance, w_finish;
   logic [IDX_W-1:0]       w_nextIdx;
   logic                   w_nextLast;
   logic [ACC_WIDTH-1:0]   w_loadAcc;
   logic [DATA_WIDTH:0]    w_word;

   // Returns {saturated, word}; the flag travels with the word so it is counted at its handshake
   function automatic logic [DATA_WIDTH:0] rescale(input logic [ACC_WIDTH-1:0] acc);
      logic signed [ACC_WIDTH-1:0] s;
      s = $signed(acc) >>> FRAC_SHIFT;
      if (s > MAX_S)
         rescale = {1'b1, MAX_W};
      else if (s < MIN_S)
         rescale = {1'b1, MIN_W};
      else
         rescale = {1'b0, s[DATA_WIDTH-1:0]};
   endfunction

   assign w_nextIdx  = r_idx + IDX_W'(1);
   assign w_nextLast = (w_nextIdx == IDX_W'(NUM_NEURONS - 1));
   // Word 0 comes straight off the input bus so it is ready the cycle after capture
   assign w_loadAcc  = w_capture ? acc_data[ACC_WIDTH-1:0] : r_acc[w_nextIdx];
   assign w_word     = rescale(w_loadAcc);

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      w_capture   = 1'b0;
      w_advance   = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         IDLE: begin
            if (acc_valid) begin
               w_capture   = 1'b1;
               w_nextState = SEND;
            end
         end
         SEND: begin
            if (m_ready) begin
               if (r_last) begin
                  w_finish    = 1'b1;
                  w_nextState = IDLE;
               end else begin
                  w_advance = 1'b1;
               end
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_NEURONS; i++)
            r_acc[i] <= '0;
         r_idx      <= '0;
         r_data     <= '0;
         r_last     <= 1'b0;
         r_sat      <= 1'b0;
         r_satCount <= '0;
      end else begin
         if (w_capture) begin
            for (int i = 0; i < NUM_NEURONS; i++)
               r_acc[i] <= acc_data[i*ACC_WIDTH +: ACC_WIDTH];
            r_idx  <= '0;
            r_data <= w_word[DATA_WIDTH-1:0];
            r_sat  <= w_word[DATA_WIDTH];
            r_last <= 1'b0;
         end else if (w_advance) begin
            r_idx  <= w_nextIdx;
            r_data <= w_word[DATA_WIDTH-1:0];
            r_sat  <= w_word[DATA_WIDTH];
            r_last <= w_nextLast;
         end else if (w_finish) begin
            r_idx  <= '0;
            r_last <= 1'b0;
            r_sat  <= 1'b0;
         end
         if ((w_advance || w_finish) && r_sat && (r_satCount != 8'hFF))
            r_satCount <= r_satCount + 8'd1;
      end
   end

   assign acc_ready = (r_state == IDLE);
   assign m_valid   = (r_state == SEND);
   assign busy      = (r_state == SEND);
   assign m_data    = r_data;
   assign m_index   = r_idx;
   assign m_last    = r_last;
   assign sat_count = r_satCount;

endmodule

// File: tb/tb_fc_result_streamer.sv
// Directed testbench for fc_result_streamer: framing, saturation, backpressure,
// busy-time capture blocking, mid-frame reset and the sat_count ceiling.
module tb_fc_result_streamer;

   localparam int DW = 16;
   localparam int AW = 32;
   localparam int NN = 10;
   localparam int IW = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              acc_valid;
   logic              acc_ready;
   logic [NN*AW-1:0]  acc_data;
   logic              m_valid;
   logic              m_ready;
   logic [DW-1:0]     m_data;
   logic [IW-1:0]     m_index;
   logic              m_last;
   logic              busy;
   logic [7:0]        sat_count;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0]     expWords [NN];
   logic [NN*AW-1:0]  vec;

   always #5 clk = ~clk;

   fc_result_streamer #(
      .DATA_WIDTH(DW), .ACC_WIDTH(AW), .NUM_NEURONS(NN), .FRAC_SHIFT(8)
   ) dut (
      .clk(clk), .rst(rst),
      .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_index(m_index), .m_last(m_last), .busy(busy), .sat_count(sat_count)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Presents a vector at a negedge in IDLE; returns at the following negedge
   task automatic applyStimulus(input logic [NN*AW-1:0] v, input bit hold);
      acc_valid = 1'b1;
      acc_data  = v;
      checkOutput("capture ready", 32'(acc_ready), 32'd1);
      @(negedge clk);
      acc_valid = hold;
      checkOutput("first word latency", 32'(m_valid), 32'd1);
   endtask

   task automatic drainFrame(input bit scramble);
      for (int i = 0; i < NN; i++) begin
         m_ready = 1'b1;
         if (scramble)
            acc_data = ~acc_data;
         checkOutput($sformatf("valid[%0d]", i), 32'(m_valid), 32'd1);
         checkOutput($sformatf("data[%0d]", i), 32'(m_data), 32'(expWords[i]));
         checkOutput($sformatf("index[%0d]", i), 32'(m_index), 32'(i));
         checkOutput($sformatf("last[%0d]", i), 32'(m_last), 32'(i == NN - 1));
         checkOutput($sformatf("busy/ready[%0d]", i), {30'd0, busy, acc_ready}, 32'h2);
         @(negedge clk);
      end
      m_ready = 1'b0;
      checkOutput("end valid", 32'(m_valid), 32'd0);
      checkOutput("end acc_ready", 32'(acc_ready), 32'd1);
      checkOutput("end last", 32'(m_last), 32'd0);
   endtask

   initial begin
      int k;
      int c;

      rst = 1'b1; acc_valid = 1'b0; acc_data = '0; m_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst acc_ready", 32'(acc_ready), 32'd1);
      checkOutput("rst m_valid", 32'(m_valid), 32'd0);
      checkOutput("rst m_data", 32'(m_data), 32'd0);
      checkOutput("rst m_index", 32'(m_index), 32'd0);
      checkOutput("rst m_last", 32'(m_last), 32'd0);
      checkOutput("rst busy", 32'(busy), 32'd0);
      checkOutput("rst sat_count", 32'(sat_count), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Basic frame: 0x1200 + i*256 >>> 8 = 0x12 + i
      for (int i = 0; i < NN; i++) begin
         vec[i*AW +: AW] = 32'h0000_1200 + 32'(i * 256);
         expWords[i]     = 16'h0012 + 16'(i);
      end
      applyStimulus(vec, 1'b0);
      drainFrame(1'b0);
      checkOutput("frame1 sat_count", 32'(sat_count), 32'd0);

      // Saturation and both boundaries: five of ten words saturate
      vec[0*AW +: AW] = 32'h0100_0000; expWords[0] = 16'h7FFF;
      vec[1*AW +: AW] = 32'hFF00_0000; expWords[1] = 16'h8000;
      vec[2*AW +: AW] = 32'hFFFF_FF00; expWords[2] = 16'hFFFF;
      vec[3*AW +: AW] = 32'h7FFF_FF00; expWords[3] = 16'h7FFF;
      vec[4*AW +: AW] = 32'h0000_0000; expWords[4] = 16'h0000;
      vec[5*AW +: AW] = 32'hFFFF_FFFF; expWords[5] = 16'hFFFF;
      vec[6*AW +: AW] = 32'h007F_FF00; expWords[6] = 16'h7FFF;
      vec[7*AW +: AW] = 32'h0080_0000; expWords[7] = 16'h7FFF;
      vec[8*AW +: AW] = 32'hFF80_0000; expWords[8] = 16'h8000;
      vec[9*AW +: AW] = 32'hFF7F_FFFF; expWords[9] = 16'h8000;
      applyStimulus(vec, 1'b0);
      drainFrame(1'b0);
      checkOutput("sat frame sat_count", 32'(sat_count), 32'd5);

      // Backpressure with m_ready pattern 1,0,0,1; even neurons saturate
      for (int i = 0; i < NN; i++) begin
         vec[i*AW +: AW] = (i % 2 == 0) ? 32'h4000_0000 : 32'(i * 256);
         expWords[i]     = (i % 2 == 0) ? 16'h7FFF : 16'(i);
      end
      applyStimulus(vec, 1'b0);
      k = 0;
      c = 0;
      while (k < NN && c < 100) begin
         m_ready = (c % 4 == 0) || (c % 4 == 3);
         checkOutput("bp valid", 32'(m_valid), 32'd1);
         checkOutput("bp data", 32'(m_data), 32'(expWords[k]));
         checkOutput("bp index", 32'(m_index), 32'(k));
         checkOutput("bp sat_count", 32'(sat_count), 32'(5 + (k + 1) / 2));
         @(negedge clk);
         if (m_ready) k++;
         c++;
      end
      m_ready = 1'b0;
      checkOutput("bp handshakes", 32'(k), 32'd10);
      checkOutput("bp cycles", 32'(c), 32'd20);
      checkOutput("bp end valid", 32'(m_valid), 32'd0);
      checkOutput("bp sat_count end", 32'(sat_count), 32'd10);

      // acc_valid held high while busy with changing data
      for (int i = 0; i < NN; i++) begin
         vec[i*AW +: AW] = 32'hFFFF_FF00 - 32'(i * 256);
         expWords[i]     = 16'hFFFF - 16'(i);
      end
      applyStimulus(vec, 1'b1);
      drainFrame(1'b1);
      for (int i = 0; i < NN; i++) begin
         vec[i*AW +: AW] = 32'(i * 3 * 256);
         expWords[i]     = 16'(i * 3);
      end
      acc_data = vec;
      @(negedge clk);
      acc_valid = 1'b0;
      checkOutput("held next capture valid", 32'(m_valid), 32'd1);
      drainFrame(1'b0);
      checkOutput("held sat_count", 32'(sat_count), 32'd10);

      // Reset after the 4th handshake
      for (int i = 0; i < NN; i++) begin
         vec[i*AW +: AW] = 32'h0000_1200 + 32'(i * 256);
         expWords[i]     = 16'h0012 + 16'(i);
      end
      applyStimulus(vec, 1'b0);
      for (int i = 0; i < 4; i++) begin
         m_ready = 1'b1;
         checkOutput("pre-reset index", 32'(m_index), 32'(i));
         @(negedge clk);
      end
      m_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midrst m_valid", 32'(m_valid), 32'd0);
      checkOutput("midrst acc_ready", 32'(acc_ready), 32'd1);
      checkOutput("midrst sat_count", 32'(sat_count), 32'd0);
      checkOutput("midrst m_index", 32'(m_index), 32'd0);
      for (int i = 0; i < NN; i++) begin
         vec[i*AW +: AW] = 32'(i * 3 * 256);
         expWords[i]     = 16'(i * 3);
      end
      applyStimulus(vec, 1'b0);
      drainFrame(1'b0);

      // sat_count ceiling: ten saturating words per frame
      for (int i = 0; i < NN; i++) begin
         vec[i*AW +: AW] = 32'h7FFF_FFFF;
         expWords[i]     = 16'h7FFF;
      end
      for (int f = 1; f <= 27; f++) begin
         applyStimulus(vec, 1'b0);
         drainFrame(1'b0);
         if (f == 1)  checkOutput("ceil f1", 32'(sat_count), 32'd10);
         if (f == 25) checkOutput("ceil f25", 32'(sat_count), 32'd250);
         if (f == 26) checkOutput("ceil f26", 32'(sat_count), 32'd255);
         if (f == 27) checkOutput("ceil f27", 32'(sat_count), 32'd255);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
